// File: rtl/i2c_reg_target.sv
// I2C target with a small register file: oversampled bus decode, pointer/data
// writes with auto-increment, reads from reg[ptr], parallel register export.
module i2c_reg_target #(
  parameter int NREGS = 4,
  parameter int PTRW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           own_addr,
  input  logic                 scl,
  inout  wire                  sda,
  output logic [8*NREGS-1:0]   reg_flat,
  output logic                 wr_stb,
  output logic [PTRW-1:0]      wr_idx,
  output logic [7:0]           wr_data,
  output logic                 addressed,
  output logic [3:0]           fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_IGNORE
  } state_t;

  // Handshake: none on the register side; wr_stb is a one-cycle qualifier
  // for wr_idx/wr_data, with no back-pressure.

  state_t          state, state_d;
  logic            scl_s1, scl_s2, scl_s3;
  logic            sda_s1, sda_s2, sda_s3;
  logic            scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [7:0]      rx_byte;
  logic            byte_done;
  logic            addr_match;
  logic            rw_q;
  logic            sda_oe;
  logic            mack_seen;
  logic [PTRW-1:0] ptr;
  logic [7:0]      regs [NREGS];

  // Reset to the idle-bus level so release from reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {scl_s1, scl_s2, scl_s3} <= 3'b111;
      {sda_s1, sda_s2, sda_s3} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_s3} <= {scl, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_s3} <= {sda, sda_s1, sda_s2};
    end
  end

  assign scl_rise   = scl_s2 & ~scl_s3;
  assign scl_fall   = ~scl_s2 & scl_s3;
  assign start_det  = scl_s2 & scl_s3 & sda_s3 & ~sda_s2;
  assign stop_det   = scl_s2 & scl_s3 & ~sda_s3 & sda_s2;
  assign rx_byte    = {shreg[6:0], sda_s2};
  assign byte_done  = scl_rise && (bit_cnt == 3'd7) &&
                      (state == S_ADDR || state == S_PTR || state == S_WDATA);
  assign addr_match = (rx_byte[7:1] == own_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_ADDR:      if (byte_done) state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:  if (scl_fall && sda_oe) state_d = rw_q ? S_RDATA : S_PTR;
        S_PTR:       if (byte_done) state_d = S_PTR_ACK;
        S_PTR_ACK:   if (scl_fall && sda_oe) state_d = S_WDATA;
        S_WDATA:     if (byte_done) state_d = S_WDATA_ACK;
        S_WDATA_ACK: if (scl_fall && sda_oe) state_d = S_WDATA;
        S_RDATA:     if (scl_rise && bit_cnt == 3'd7) state_d = S_MACK;
        S_MACK: begin
          if (scl_rise && sda_s2)        state_d = S_IGNORE;
          else if (scl_fall && mack_seen) state_d = S_RDATA;
        end
        default:     state_d = state;
      endcase
    end
  end

  always_comb begin
    fsm_state = 4'(state);
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Datapath; ACK states use sda_oe as the phase flag (first fall drives,
  // second fall releases and leaves).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      mack_seen <= 1'b0;
      ptr       <= '0;
      wr_stb    <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      addressed <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
        mack_seen <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
              if (state == S_ADDR && addr_match) begin
                addressed <= 1'b1;
                rw_q      <= sda_s2;
              end
              if (state == S_PTR) ptr <= rx_byte[PTRW-1:0];
              if (state == S_WDATA) begin
                regs[ptr] <= rx_byte;
                wr_stb    <= 1'b1;
                wr_idx    <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + PTRW'(1);
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (rw_q) begin
                shreg  <= regs[ptr];
                sda_oe <= ~regs[ptr][7];
              end else begin
                sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) sda_oe <= ~sda_oe;
          end
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) mack_seen <= 1'b0;
            end
            if (scl_fall) begin
              sda_oe <= ~shreg[6];
              shreg  <= {shreg[6:0], 1'b0};
            end
          end
          S_MACK: begin
            if (scl_rise) begin
              ptr       <= ptr + PTRW'(1);
              mack_seen <= ~sda_s2;
            end
            if (scl_fall) begin
              if (!mack_seen) begin
                sda_oe <= 1'b0;
              end else begin
                shreg     <= regs[ptr];
                sda_oe    <= ~regs[ptr][7];
                bit_cnt   <= '0;
                mack_seen <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NREGS; i++) reg_flat[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: a bit-banged I2C master drives the bus
// and a write scoreboard checks every wr_stb pulse.
module tb_i2c_reg_target;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scl_m;
  logic        sda_low;
  wire         sda_bus;
  logic [31:0] reg_flat;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        addressed;
  logic [3:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_target #(.NREGS(4), .PTRW(2)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .own_addr  (7'b1010001),
    .scl       (scl_m),
    .sda       (sda_bus),
    .reg_flat  (reg_flat),
    .wr_stb    (wr_stb),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .addressed (addressed),
    .fsm_state (fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every wr_stb cycle must match the next expected {idx,data}.
  always @(negedge clk) begin
    if (rst_n && wr_stb) begin
      if (exp_q.size() == 0) check("wr_unexpected", 32'(wr_stb), 32'd0);
      else check("wr_idx_data", 32'({wr_idx, wr_data}), 32'(exp_q.pop_front()));
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic bus_released();
    return (sda_bus !== 1'b0);
  endfunction

  task automatic i2c_start();
    sda_low = 1'b0;
    wait_clk(8);
    scl_m = 1'b1;
    wait_clk(8);
    sda_low = 1'b1;
    wait_clk(8);
    scl_m = 1'b0;
    wait_clk(3);
  endtask

  task automatic i2c_stop();
    wait_clk(3);
    sda_low = 1'b1;
    wait_clk(5);
    scl_m = 1'b1;
    wait_clk(8);
    sda_low = 1'b0;
    wait_clk(10);
  endtask

  // Entered and left with scl low.
  task automatic clock_bit(input logic b, output logic r);
    wait_clk(3);
    sda_low = ~b;
    wait_clk(7);
    scl_m = 1'b1;
    wait_clk(5);
    r = bus_released();
    wait_clk(5);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~master_ack, r);
  endtask

  initial begin
    logic       ack;
    logic       r;
    logic [7:0] d;
    rst_n   = 1'b0;
    scl_m   = 1'b1;
    sda_low = 1'b0;
    wait_clk(5);
    check("rst_reg_flat", reg_flat, 32'h0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_addressed", 32'(addressed), 32'd0);
    check("rst_sda_released", 32'(bus_released()), 32'd1);
    rst_n = 1'b1;
    wait_clk(10);

    // Write 0xA5 to reg1
    i2c_start();
    write_byte(8'hA2, ack);
    check("wr_addr_ack", 32'(ack), 32'd1);
    check("wr_addressed", 32'(addressed), 32'd1);
    write_byte(8'h01, ack);
    check("wr_ptr_ack", 32'(ack), 32'd1);
    exp_q.push_back({2'd1, 8'hA5});
    write_byte(8'hA5, ack);
    check("wr_data_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("wr_reg1", 32'(reg_flat[15:8]), 32'hA5);
    check("wr_addressed_after_stop", 32'(addressed), 32'd0);

    // Pointer write, repeated start, read two bytes
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h01, ack);
    check("rd_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'hA3, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d);
    check("rd_byte0", 32'(d), 32'hA5);
    read_byte(1'b0, d);
    check("rd_byte1", 32'(d), 32'h00);
    wait_clk(6);
    check("rd_sda_released", 32'(bus_released()), 32'd1);
    check("rd_ptr_final", 32'(dut.ptr), 32'd3);
    i2c_stop();

    // Wrong address: nothing acknowledged or written
    i2c_start();
    write_byte(8'hA4, ack);
    check("bad_addr_nack", 32'(ack), 32'd0);
    check("bad_addressed", 32'(addressed), 32'd0);
    write_byte(8'h00, ack);
    check("bad_ptr_nack", 32'(ack), 32'd0);
    write_byte(8'h33, ack);
    check("bad_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    check("bad_regs", reg_flat, 32'h0000A500);

    // Auto-increment wrap from reg3 to reg0
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h03, ack);
    exp_q.push_back({2'd3, 8'h11});
    write_byte(8'h11, ack);
    exp_q.push_back({2'd0, 8'h22});
    write_byte(8'h22, ack);
    check("wrap_last_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("wrap_regs", reg_flat, 32'h1100A522);

    // Pointer upper bits ignored: 0xFE selects reg2
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'hFE, ack);
    exp_q.push_back({2'd2, 8'h5A});
    write_byte(8'h5A, ack);
    i2c_stop();
    check("trunc_regs", reg_flat, 32'h115AA522);

    // Reset after 4 data bits of a write
    i2c_start();
    write_byte(8'hA2, ack);
    write_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
    rst_n = 1'b0;
    wait_clk(3);
    check("mid_rst_reg_flat", reg_flat, 32'h0);
    check("mid_rst_outs", 32'({wr_stb, wr_idx, wr_data, addressed}), 32'd0);
    check("mid_rst_sda", 32'(bus_released()), 32'd1);
    rst_n = 1'b1;
    wait_clk(3);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, r);
    clock_bit(1'b1, r);
    check("mid_rst_no_ack", 32'(r), 32'd1);
    write_byte(8'h42, ack);
    check("mid_rst_next_nack", 32'(ack), 32'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'hA2, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h01, ack);
    exp_q.push_back({2'd1, 8'h77});
    write_byte(8'h77, ack);
    i2c_stop();
    check("post_rst_regs", reg_flat, 32'h00007700);

    wait_clk(5);
    check("wr_all_seen", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
